// File: rtl/risc16_pkg.sv
// Shared types and constants for the 16-bit RISC core pipeline.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package risc16_pkg;

    // Datapath and register-file address widths
    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    // Memory / writeback control bits carried alongside each instruction
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
    } ex_ctrl_t;

    localparam int CTRL_W = $bits(ex_ctrl_t);

    // Conditional branch flavour presented by EX
    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_kind_t;

    // Occupancy of the two-entry elastic buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // BEQ wins when both branch bits are set, so an illegal encoding still
    // behaves deterministically.
    function automatic br_kind_t br_decode(input logic beq, input logic bne);
        br_kind_t kind;
        if (beq) begin
            kind = BR_EQ;
        end else if (bne) begin
            kind = BR_NE;
        end else begin
            kind = BR_NONE;
        end
        return kind;
    endfunction

    // Branch outcome from the ALU zero flag
    function automatic logic br_resolve(input br_kind_t kind, input logic zero);
        logic taken;
        case (kind)
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/fifo2.sv
// Two-entry register FIFO with push/pop/flush, occupancy count and head view.
// Latency: a push at cycle N is visible at o_head_dat at N+1 when the FIFO was empty.
// Backpressure: pushes when full and pops when empty are ignored; flush overrides both.
module fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [1:0]       o_count,
    output logic [1:0]       o_count_nxt,
    output logic [WIDTH-1:0] o_head_dat
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_push;
    logic             w_pop;

    // Guard against overflow/underflow so the caller cannot corrupt the count
    assign w_push = i_push & ~i_flush & (r_count != 2'd2);
    assign w_pop  = i_pop  & ~i_flush & (r_count != 2'd0);

    // Next occupancy; also consumed by the owner to register its ready signal
    always_comb begin
        o_count_nxt = r_count;
        if (i_flush) begin
            o_count_nxt = 2'd0;
        end else begin
            o_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage, pointers and count; pointers are 1 bit and wrap naturally 1->0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_count <= o_count_nxt;
            if (i_flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= i_push_dat;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM stage: 2-entry elastic buffer, BEQ/BNE resolve with PC redirect, forwarding tap.
// Latency: accept at cycle N shows on out_* and branch_taken at N+1; no comb in->out path.
// Backpressure: in_ready is registered and low only while both entries are occupied.
module ex_mem_stage
    import risc16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_zero,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic              in_beq,
    input  logic              in_bne,
    input  logic [DATA_W-1:0] in_br_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target
);

    localparam int ENTRY_W = 2 * DATA_W + REG_AW + CTRL_W;

    ex_ctrl_t           w_in_ctrl;
    ex_ctrl_t           w_head_ctrl;
    logic [ENTRY_W-1:0] w_push_dat;
    logic [ENTRY_W-1:0] w_head_dat;
    logic [1:0]         w_count;
    logic [1:0]         w_count_nxt;
    br_kind_t           w_br_kind;
    logic               w_accept;
    logic               w_enqueue;
    logic               w_pop;
    logic               w_taken;

    logic               r_in_ready;
    logic               r_branch_taken;
    logic [DATA_W-1:0]  r_branch_target;

    assign w_in_ctrl = '{mem_read:  in_mem_read,
                         mem_write: in_mem_write,
                         reg_write: in_reg_write};

    // Handshakes. Instructions with no memory or writeback effect (branches,
    // nops) complete here and never occupy a buffer slot.
    assign w_accept  = in_valid & r_in_ready;
    assign w_enqueue = w_accept & (|w_in_ctrl);
    assign w_pop     = out_valid & out_ready;

    // A flushed cycle must not redirect, even if the branch was accepted
    assign w_br_kind = br_decode(in_beq, in_bne);
    assign w_taken   = w_accept & ~flush & br_resolve(w_br_kind, in_zero);

    assign w_push_dat = {in_alu_result, in_store_data, in_rd, w_in_ctrl};

    fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_push      (w_enqueue),
        .i_push_dat  (w_push_dat),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt),
        .o_head_dat  (w_head_dat)
    );

    // Ready registered from next occupancy so EX never sees a comb path from out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_count_nxt != BUF_FULL);
        end
    end

    // One-cycle redirect pulse; target holds its last value between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
        end else begin
            r_branch_taken <= w_taken;
            if (w_taken) begin
                r_branch_target <= in_br_target;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (w_count != BUF_EMPTY);

    assign {out_alu_result, out_store_data, out_rd, w_head_ctrl} = w_head_dat;
    assign out_mem_read  = w_head_ctrl.mem_read;
    assign out_mem_write = w_head_ctrl.mem_write;
    assign out_reg_write = w_head_ctrl.reg_write;

    // Loads are excluded: their result is an address, not the writeback value
    assign fwd_valid = out_valid & out_reg_write & ~out_mem_read;
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_alu_result;

    assign branch_taken  = r_branch_taken;
    assign branch_target = r_branch_target;

endmodule
